// File: rtl/tl_source_allocator.sv
// ============================================================================
// Module   : tl_source_allocator
// Brief    : TileLink-UH source-ID allocator for a single sourceless client.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tl_source_allocator #(
    parameter int SOURCE_BITS  = 1,
    parameter int MAX_INFLIGHT = 2,
    parameter int LOG_BEAT     = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    // client A
    output logic                   in_a_ready,
    input  logic                   in_a_valid,
    input  logic [2:0]             in_a_opcode,
    input  logic [3:0]             in_a_size,
    input  logic [32:0]            in_a_address,
    input  logic [7:0]             in_a_mask,
    input  logic [63:0]            in_a_data,
    // downstream A
    input  logic                   out_a_ready,
    output logic                   out_a_valid,
    output logic [2:0]             out_a_opcode,
    output logic [2:0]             out_a_param,
    output logic [3:0]             out_a_size,
    output logic [SOURCE_BITS-1:0] out_a_source,
    output logic [32:0]            out_a_address,
    output logic [7:0]             out_a_mask,
    output logic [63:0]            out_a_data,
    output logic                   out_a_corrupt,
    // downstream D
    output logic                   out_d_ready,
    input  logic                   out_d_valid,
    input  logic [2:0]             out_d_opcode,
    input  logic [1:0]             out_d_param,
    input  logic [3:0]             out_d_size,
    input  logic [SOURCE_BITS-1:0] out_d_source,
    input  logic [2:0]             out_d_sink,
    input  logic                   out_d_denied,
    input  logic [63:0]            out_d_data,
    input  logic                   out_d_corrupt,
    // client D
    input  logic                   in_d_ready,
    output logic                   in_d_valid,
    output logic [2:0]             in_d_opcode,
    output logic [1:0]             in_d_param,
    output logic [3:0]             in_d_size,
    output logic [SOURCE_BITS-1:0] in_d_source,
    output logic [2:0]             in_d_sink,
    output logic                   in_d_denied,
    output logic [63:0]            in_d_data,
    output logic                   in_d_corrupt,
    // status
    output logic [SOURCE_BITS:0]   inflight,
    output logic                   err_spurious_d
);

    localparam int                 c_num_ids      = 2 ** SOURCE_BITS;
    localparam logic [SOURCE_BITS:0] c_max_inflight = (SOURCE_BITS + 1)'(MAX_INFLIGHT);
    localparam logic [3:0]         c_log_beat     = 4'(LOG_BEAT);

    logic [c_num_ids-1:0]   r_free;
    logic                   r_a_busy;
    logic [3:0]             r_a_left;
    logic [SOURCE_BITS-1:0] r_a_src;
    logic [3:0]             r_d_left [c_num_ids];
    logic [SOURCE_BITS:0]   r_inflight;
    logic                   r_err;

    logic [SOURCE_BITS-1:0] w_free_idx;
    logic                   w_can_alloc;
    logic                   w_gate;
    logic                   w_a_fire;
    logic                   w_alloc;
    logic [3:0]             w_a_beats_m1;
    logic [3:0]             w_d_beats_m1;
    logic                   w_d_fire;
    logic                   w_d_last;
    logic                   w_d_free;
    logic                   w_d_spur;
    logic [3:0]             w_d_left_cur;
    logic [c_num_ids-1:0]   w_free_nxt;

    // Number of beats minus one; messages without data are always one beat.
    function automatic logic [3:0] beats_m1(input logic has_data, input logic [3:0] size);
        logic [15:0] v;
        v = '0;
        if (has_data && (size > c_log_beat)) begin
            v = (16'd1 << (size - c_log_beat)) - 16'd1;
        end
        return v[3:0];
    endfunction

    always_comb begin
        w_free_idx = '0;
        for (int i = c_num_ids - 1; i >= 0; i--) begin
            if (r_free[i]) begin
                w_free_idx = SOURCE_BITS'(i);
            end
        end
    end

    assign w_can_alloc  = (|r_free) && (r_inflight < c_max_inflight);
    assign w_gate       = r_a_busy | w_can_alloc;
    assign out_a_valid  = reset & in_a_valid & w_gate;
    assign in_a_ready   = reset & out_a_ready & w_gate;
    assign out_a_source = r_a_busy ? r_a_src : w_free_idx;

    assign out_a_opcode  = in_a_opcode;
    assign out_a_param   = 3'd0;
    assign out_a_size    = in_a_size;
    assign out_a_address = in_a_address;
    assign out_a_mask    = in_a_mask;
    assign out_a_data    = in_a_data;
    assign out_a_corrupt = 1'b0;

    assign out_d_ready  = in_d_ready;
    assign in_d_valid   = out_d_valid;
    assign in_d_opcode  = out_d_opcode;
    assign in_d_param   = out_d_param;
    assign in_d_size    = out_d_size;
    assign in_d_source  = out_d_source;
    assign in_d_sink    = out_d_sink;
    assign in_d_denied  = out_d_denied;
    assign in_d_data    = out_d_data;
    assign in_d_corrupt = out_d_corrupt;

    assign w_a_fire     = in_a_valid & in_a_ready;
    assign w_alloc      = w_a_fire & ~r_a_busy;
    assign w_a_beats_m1 = beats_m1(in_a_opcode <= 3'd3, in_a_size);
    assign w_d_beats_m1 = beats_m1(out_d_opcode == 3'd1, out_d_size);
    assign w_d_left_cur = r_d_left[out_d_source];
    assign w_d_fire     = out_d_valid & in_d_ready;
    assign w_d_last     = w_d_fire & ((w_d_beats_m1 == 4'd0) || (w_d_left_cur == 4'd1));
    assign w_d_free     = w_d_last & ~r_free[out_d_source];
    assign w_d_spur     = w_d_last & r_free[out_d_source];

    // The allocated ID was free, so it can never collide with the ID being freed.
    always_comb begin
        w_free_nxt = r_free;
        if (w_alloc) begin
            w_free_nxt[w_free_idx] = 1'b0;
        end
        if (w_d_free) begin
            w_free_nxt[out_d_source] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_free     <= '1;
            r_a_busy   <= 1'b0;
            r_a_left   <= 4'd0;
            r_a_src    <= '0;
            r_inflight <= '0;
            r_err      <= 1'b0;
            for (int i = 0; i < c_num_ids; i++) begin
                r_d_left[i] <= 4'd0;
            end
        end else begin
            r_free <= w_free_nxt;

            if (w_alloc && !w_d_free) begin
                r_inflight <= r_inflight + 1'b1;
            end else if (!w_alloc && w_d_free) begin
                r_inflight <= r_inflight - 1'b1;
            end

            if (w_alloc) begin
                if (w_a_beats_m1 != 4'd0) begin
                    r_a_busy <= 1'b1;
                    r_a_src  <= w_free_idx;
                    r_a_left <= w_a_beats_m1;
                end
            end else if (w_a_fire) begin
                r_a_left <= r_a_left - 4'd1;
                if (r_a_left == 4'd1) begin
                    r_a_busy <= 1'b0;
                end
            end

            if (w_d_fire) begin
                if (w_d_last) begin
                    r_d_left[out_d_source] <= 4'd0;
                end else if (w_d_left_cur == 4'd0) begin
                    r_d_left[out_d_source] <= w_d_beats_m1;
                end else begin
                    r_d_left[out_d_source] <= w_d_left_cur - 4'd1;
                end
            end

            if (w_d_spur) begin
                r_err <= 1'b1;
            end
        end
    end

    assign inflight       = r_inflight;
    assign err_spurious_d = r_err;

endmodule

`default_nettype wire
